if_id_reg: RTL
==============

Name: if_id_reg

Overview:
- Pipeline register between the fetch stage (PC register plus instruction memory) and the decode stage of the 5-stage MIPS core.
- Captures the fetched PC and instruction word, and provides PC+8 as the link address.
- Holds its contents under freeze and inserts bubbles on clear.
- A clear that arrives while frozen is remembered, so it is never lost.
- Keeps saturating performance counters for fetches, stall cycles and bubbles.

Parameters:
- PC_RESET, 32'h0000_3000, D_PC value after reset; matches the fetch-stage reset PC.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- F_PC  in  32  PC of the instruction being fetched this cycle.
- F_Instr  in  32  instruction word read from instruction memory at F_PC.
- freeze  in  1  stall from the hazard unit: hold all D_* outputs.
- clr  in  1  discard the fetch-stage instruction and insert a bubble.
- cnt_clr  in  1  synchronous clear of the three counters only.
- D_PC  out  32  registered PC.
- D_Instr  out  32  registered instruction; 32'h0 (sll $0,$0,0 = nop) when it is a bubble.
- D_PC8  out  32  D_PC + 32'd8, combinational from D_PC; wraps modulo 2^32.
- D_valid  out  1  1 = D_Instr is a real fetched instruction.
- cnt_fetch  out  CNT_W  number of valid instructions loaded.
- cnt_stall  out  CNT_W  number of cycles with freeze=1.
- cnt_bubble  out  CNT_W  number of bubbles inserted.

Behaviour:
- Reset: D_PC=PC_RESET, D_Instr=0, D_valid=0, all counters 0, FSM=RUN.
  - Reset has priority over every other input, including mid-freeze and a pending clear.
- FSM states: RUN and CLR_PEND.
- Each edge while not in reset evaluates the first matching case, in this order:
  1. freeze=1: D_PC, D_Instr and D_valid hold. cnt_stall += 1.
     - If clr=1 or state=CLR_PEND, go to CLR_PEND; otherwise stay in RUN.
  2. freeze=0 with (clr=1 or state=CLR_PEND): load a bubble.
     - D_PC=F_PC, D_Instr=0, D_valid=0.
     - cnt_bubble += 1, state goes to RUN.
  3. freeze=0, clr=0, state=RUN: normal load.
     - D_PC=F_PC, D_Instr=F_Instr, D_valid=1.
     - cnt_fetch += 1.
- A pending clear is consumed exactly once, on the first unfrozen edge, and yields exactly one bubble.
- A clr held high across several unfrozen cycles gives one bubble per cycle.
- Latency: one cycle from F_* to D_*; there is no combinational path from F_* to D_*.
- D_PC8 is pure combinational: D_PC=32'hFFFF_FFFC gives D_PC8=32'h0000_0004.
- Counters:
  - Unsigned, saturate at all-ones and never wrap.
  - cnt_clr=1 zeroes all three at the edge and takes priority over any increment in that same cycle.
  - cnt_clr does not touch D_* or the FSM.
- The delay slot is never cleared by this block. The hazard/branch logic must not assert clr for a delay-slot instruction; this block does not check for it.
- Outputs never go X after reset, whatever the F_* values.

Test Plan:
- Reset, then release and apply F_PC=0x3000, 0x3004, 0x3008 with distinct F_Instr on successive cycles.
  - Required: D_* follow one cycle later, D_valid=1.
  - Required: D_PC8 = 0x3008, 0x300C, 0x3010.
  - Required: cnt_fetch=3.
- Load F_PC=0x3010, then hold freeze=1 for 3 cycles while F_* change.
  - Required: D_PC stays 0x3010 with an unchanged D_Instr.
  - Required: cnt_stall=3, cnt_fetch unchanged.
- Pulse clr for 1 cycle during freeze, then drop freeze with F_PC=0x3020.
  - Required: next D_PC=0x3020, D_Instr=0, D_valid=0.
  - Required: cnt_bubble=1.
  - Required: the following unfrozen edge is a normal load (state back to RUN).
- Assert clr=1 with freeze=0 for 2 cycles.
  - Required: two bubbles, cnt_bubble=2, D_valid=0 both cycles, then D_valid=1 on the next normal load.
- Assert reset during freeze with CLR_PEND.
  - Required: D_PC=0x0000_3000, D_Instr=0, D_valid=0, counters 0.
  - Required: the first edge after release is a normal load, not a bubble.
- Counter saturation with CNT_W=4: run 20 normal loads.
  - Required: cnt_fetch=4'hF.
  - Then assert cnt_clr together with a load: cnt_fetch=0 and D_* still update.

Source files
------------

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - fetch/decode pipeline register with freeze, sticky clear and counters
module if_id_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      F_PC,
    input  logic [31:0]      F_Instr,
    input  logic             freeze,
    input  logic             clr,
    input  logic             cnt_clr,
    output logic [31:0]      D_PC,
    output logic [31:0]      D_Instr,
    output logic [31:0]      D_PC8,
    output logic             D_valid,
    output logic [CNT_W-1:0] cnt_fetch,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_bubble
);

    typedef enum logic {
        RUN,
        CLR_PEND
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] fetch_q, fetch_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic             do_stall, do_bubble, do_fetch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        do_stall  = 1'b0;
        do_bubble = 1'b0;
        do_fetch  = 1'b0;

        // A clear seen while frozen is parked in CLR_PEND until the first unfrozen edge.
        if (freeze) begin
            do_stall = 1'b1;
            state_d  = (clr || state_q == CLR_PEND) ? CLR_PEND : RUN;
        end else if (clr || state_q == CLR_PEND) begin
            do_bubble = 1'b1;
            pc_d      = F_PC;
            instr_d   = 32'h0;
            valid_d   = 1'b0;
            state_d   = RUN;
        end else begin
            do_fetch = 1'b1;
            pc_d     = F_PC;
            instr_d  = F_Instr;
            valid_d  = 1'b1;
        end
    end

    always_comb begin
        fetch_d  = fetch_q;
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (cnt_clr) begin
            fetch_d  = CNT_ZERO;
            stall_d  = CNT_ZERO;
            bubble_d = CNT_ZERO;
        end else begin
            if (do_fetch)  fetch_d  = sat_inc(fetch_q);
            if (do_stall)  stall_d  = sat_inc(stall_q);
            if (do_bubble) bubble_d = sat_inc(bubble_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= PC_RESET;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            fetch_q  <= CNT_ZERO;
            stall_q  <= CNT_ZERO;
            bubble_q <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            fetch_q  <= fetch_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign D_PC       = pc_q;
    assign D_Instr    = instr_q;
    assign D_valid    = valid_q;
    assign D_PC8      = pc_q + 32'd8;
    assign cnt_fetch  = fetch_q;
    assign cnt_stall  = stall_q;
    assign cnt_bubble = bubble_q;

endmodule
